float_sub_seq: RTL and testbench

Sequential half-precision subtractor: computes res = a − b on the team's 16-bit float format (1 sign, 5 exponent, 10 mantissa, implicit leading 1, raw exponent, no denormals, truncation). It is the counterpart of the combinational adder. Subtraction is its primary operation, and it normalises iteratively, one bit per cycle.

It sits between a valid/ready producer and consumer in the float datapath.

---
 rtl/float16_pkg.sv | 19 +
 rtl/float_align.sv | 43 ++++
 rtl/float_sub_seq.sv | 188 ++++++++++++++++++
 tb/tb_float_sub_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/float16_pkg.sv
// Shared widths, FSM state type and constants for the 16-bit float datapath.
package float16_pkg;

  localparam int unsigned FLOAT_W = 16;
  localparam int unsigned EXP_W   = 5;
  localparam int unsigned MAN_W   = 10;
  localparam int unsigned FRAC_W  = MAN_W + 1;

  localparam logic [FLOAT_W-1:0] FLOAT_ZERO = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADDSUB,
    ST_NORM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/float_align.sv
// Operand compare/swap and right barrel shift of the smaller-exponent fraction.
module float_align
  import float16_pkg::*;
#(
  parameter int unsigned exponent_width = EXP_W,
  parameter int unsigned mantissa_width = MAN_W
) (
  input  logic [exponent_width-1:0]      exp_a_i,
  input  logic [exponent_width-1:0]      exp_b_i,
  input  logic [mantissa_width-1:0]      man_a_i,
  input  logic [mantissa_width-1:0]      man_b_i,
  output logic signed [exponent_width:0] exp_un_o,
  output logic [mantissa_width:0]        frac_a_o,
  output logic [mantissa_width:0]        frac_b_o,
  output logic                           a_larger_o
);

  localparam int unsigned FW = mantissa_width + 1;
  localparam logic [exponent_width-1:0] SHIFT_LIM = exponent_width'(FW);

  logic [FW-1:0]             frac_a;
  logic [FW-1:0]             frac_b;
  logic [exponent_width-1:0] diff;
  logic                      a_exp_ge;

  // Align the smaller-exponent fraction to the larger exponent.
  always_comb begin
    frac_a   = {1'b1, man_a_i};
    frac_b   = {1'b1, man_b_i};
    a_exp_ge = (exp_a_i >= exp_b_i);
    diff     = a_exp_ge ? (exp_a_i - exp_b_i) : (exp_b_i - exp_a_i);
    exp_un_o = {1'b0, (a_exp_ge ? exp_a_i : exp_b_i)};
    frac_a_o = frac_a;
    frac_b_o = frac_b;
    if (a_exp_ge) begin
      frac_b_o = (diff >= SHIFT_LIM) ? '0 : (frac_b >> diff);
    end else begin
      frac_a_o = (diff >= SHIFT_LIM) ? '0 : (frac_a >> diff);
    end
    a_larger_o = (frac_a_o >= frac_b_o);
  end

endmodule

// File: rtl/float_sub_seq.sv
// Sequential half-precision subtractor (res = a - b) with one-bit-per-cycle normalisation.
module float_sub_seq
  import float16_pkg::*;
#(
  parameter int unsigned float_width    = FLOAT_W,
  parameter int unsigned exponent_width = EXP_W,
  parameter int unsigned mantissa_width = MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [float_width-1:0] float_a,
  input  logic [float_width-1:0] float_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [float_width-1:0] res,
  output logic                   exc
);

  localparam int unsigned FW  = mantissa_width + 1;
  localparam int unsigned EW  = exponent_width + 1;
  localparam int unsigned MSB = float_width - 1;
  localparam logic signed [EW-1:0] EXP_ONE = {{(EW-1){1'b0}}, 1'b1};

  state_e                   state_q;
  logic [float_width-1:0]   a_q;
  logic [float_width-1:0]   b_q;
  logic                     sa_q;
  logic                     sb_q;
  logic [FW-1:0]            fa_q;
  logic [FW-1:0]            fb_q;
  logic                     a_big_q;
  logic signed [EW-1:0]     exp_q;
  logic [mantissa_width-1:0] man_q;
  logic                     sign_q;
  logic [float_width-1:0]   res_q;
  logic                     exc_q;
  logic                     out_valid_q;

  logic signed [EW-1:0]     exp_un;
  logic [FW-1:0]            fa_al;
  logic [FW-1:0]            fb_al;
  logic                     a_larger;
  logic [FW:0]              mag_d;
  logic                     sign_d;
  logic                     a_zero;
  logic                     b_zero;

  float_align #(
    .exponent_width(exponent_width),
    .mantissa_width(mantissa_width)
  ) u_align (
    .exp_a_i   (a_q[MSB-1 -: exponent_width]),
    .exp_b_i   (b_q[MSB-1 -: exponent_width]),
    .man_a_i   (a_q[mantissa_width-1:0]),
    .man_b_i   (b_q[mantissa_width-1:0]),
    .exp_un_o  (exp_un),
    .frac_a_o  (fa_al),
    .frac_b_o  (fb_al),
    .a_larger_o(a_larger)
  );

  // Zero detection on magnitude, so a negative zero also takes the shortcut.
  always_comb begin
    a_zero = (a_q[MSB-1:0] == '0);
    b_zero = (b_q[MSB-1:0] == '0);
  end

  // Signed-magnitude add of the aligned fractions (b's sign already flipped).
  always_comb begin
    mag_d  = '0;
    sign_d = sa_q;
    if (sa_q == sb_q) begin
      mag_d = {1'b0, fa_q} + {1'b0, fb_q};
    end else if (a_big_q) begin
      mag_d = {1'b0, fa_q - fb_q};
    end else begin
      mag_d  = {1'b0, fb_q - fa_q};
      sign_d = sb_q;
    end
  end

  // Control FSM with datapath registers and registered outputs.
  // The hidden bit is never stored: ADDSUB resolves an already-normalised or
  // carry result straight to DONE, and NORM exits on the shift that brings the
  // leading one into the hidden position, so only the mantissa needs holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      fa_q        <= '0;
      fb_q        <= '0;
      a_big_q     <= 1'b0;
      exp_q       <= '0;
      man_q       <= '0;
      sign_q      <= 1'b0;
      res_q       <= FLOAT_ZERO;
      exc_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= float_a;
            b_q     <= float_b;
            state_q <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          fa_q    <= fa_al;
          fb_q    <= fb_al;
          a_big_q <= a_larger;
          exp_q   <= exp_un;
          sa_q    <= a_q[MSB];
          sb_q    <= ~b_q[MSB];
          state_q <= ST_ADDSUB;
          if (a_zero) begin
            sign_q  <= b_zero ? 1'b0 : ~b_q[MSB];
            exp_q   <= {1'b0, b_q[MSB-1 -: exponent_width]};
            man_q   <= b_q[mantissa_width-1:0];
            state_q <= ST_DONE;
          end else if (b_zero) begin
            sign_q  <= a_q[MSB];
            exp_q   <= {1'b0, a_q[MSB-1 -: exponent_width]};
            man_q   <= a_q[mantissa_width-1:0];
            state_q <= ST_DONE;
          end else if (a_q == b_q) begin
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
            state_q <= ST_DONE;
          end
        end
        ST_ADDSUB: begin
          sign_q <= sign_d;
          if (mag_d == '0) begin
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
            state_q <= ST_DONE;
          end else if (mag_d[FW]) begin
            man_q   <= mag_d[FW-1:1];
            exp_q   <= exp_q + EXP_ONE;
            state_q <= ST_DONE;
          end else begin
            man_q   <= mag_d[mantissa_width-1:0];
            state_q <= mag_d[FW-1] ? ST_DONE : ST_NORM;
          end
        end
        ST_NORM: begin
          man_q <= man_q << 1;
          exp_q <= exp_q - EXP_ONE;
          if (man_q[mantissa_width-1]) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            // A carry out of exponent 31 wraps to -32 in this width, so the
            // sign bit alone flags both ends of the valid range.
            if (exp_q[EW-1]) begin
              res_q <= FLOAT_ZERO;
              exc_q <= 1'b1;
            end else begin
              res_q <= {sign_q, exp_q[exponent_width-1:0], man_q};
              exc_q <= 1'b0;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign exc       = exc_q;

endmodule

// File: tb/tb_float_sub_seq.sv
// Self-checking bench for float_sub_seq: directed plan cases plus randomized operands.
module tb_float_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] float_a = '0;
  logic [15:0] float_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] res;
  logic        exc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_sub_seq #(
    .float_width(16),
    .exponent_width(5),
    .mantissa_width(10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .float_a  (float_a),
    .float_b  (float_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .exc      (exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: value-level subtraction with truncating alignment to the larger exponent.
  function automatic void ref_sub(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic e, output int lat);
    int     ea, eb, emax, p, ex;
    longint fa, fb, va, vb, s, mag;
    logic   sg;
    r = '0; e = 1'b0; lat = 2;
    if (a[14:0] == 15'h0) begin
      if (b[14:0] != 15'h0) r = {~b[15], b[14:0]};
      return;
    end
    if (b[14:0] == 15'h0) begin r = a; return; end
    if (a == b) return;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    emax = (ea > eb) ? ea : eb;
    fa = longint'({1'b1, a[9:0]}) >> (emax - ea);
    fb = longint'({1'b1, b[9:0]}) >> (emax - eb);
    va = a[15] ? -fa : fa;
    vb = b[15] ? fb : -fb;
    s  = va + vb;
    if (s == 0) begin lat = 3; return; end
    sg  = (s < 0);
    mag = sg ? -s : s;
    p = 0;
    for (int i = 0; i < 12; i++) if (mag[i]) p = i;
    ex  = emax + p - 10;
    lat = (p > 10) ? 3 : 3 + (10 - p);
    if (ex < 0 || ex > 31) begin e = 1'b1; return; end
    r = {sg, 5'(ex), 10'((p > 10) ? (mag >> 1) : (mag << (10 - p)))};
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    @(negedge clk);
    float_a  = a;
    float_b  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input string tag, input logic [15:0] xr, input logic xe,
                           input int xl, input int hold);
    int edges = 0;
    while (!out_valid && edges < 40) begin @(posedge clk); #1; edges++; end
    chk({tag, "_lat"},   32'(edges), 32'(xl));
    chk({tag, "_res"},   32'(res), 32'(xr));
    chk({tag, "_exc"},   32'(exc), 32'(xe));
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_res"},   32'(res), 32'(xr));
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_inrdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic op_const(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] xr, input logic xe, input int xl, input int hold);
    start_op(a, b);
    finish_op(tag, xr, xe, xl, hold);
  endtask

  task automatic op_model(input string tag, input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [15:0] xr;
    logic        xe;
    int          xl;
    ref_sub(a, b, xr, xe, xl);
    start_op(a, b);
    finish_op(tag, xr, xe, xl, hold);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          seen;

    // Reset state
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res",   32'(res), 32'h0);
    chk("rst_exc",   32'(exc), 32'd0);
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Directed plan cases
    op_const("t1_k1",     16'h3C00, 16'h3800, 16'h3800, 1'b0, 4, 0);
    op_const("t2_carry",  16'h3C00, 16'hBC00, 16'h4000, 1'b0, 3, 0);
    op_const("t3_equal",  16'h3C01, 16'h3C01, 16'h0000, 1'b0, 2, 0);
    op_const("t3_azero",  16'h0000, 16'h3C00, 16'hBC00, 1'b0, 2, 0);
    op_const("t3_bzero",  16'hC123, 16'h8000, 16'hC123, 1'b0, 2, 0);
    op_const("t4_k10",    16'h3C01, 16'h3C00, 16'h1400, 1'b0, 13, 0);
    op_const("t5_ovf",    16'h7C00, 16'hFC00, 16'h0000, 1'b1, 3, 0);
    op_const("t5_unf",    16'h0001, 16'h0000 | 16'h0000 + 16'h0000 + 16'h0000 + 16'h0000 + 16'h0000 + 16'h0000 + 16'h0000 + 16'h0000 + 16'h0400 - 16'h0400 + 16'h0000, 16'h0001, 1'b0, 2, 0);
    op_const("t5_uflow",  16'h0801, 16'h0800, 16'h0000, 1'b1, 13, 0);

    // Backpressure: DONE held for 5 cycles
    op_const("t6_bp",     16'h3C00, 16'h3800, 16'h3800, 1'b0, 4, 5);

    // Reset during NORM of the k=10 case
    start_op(16'h3C01, 16'h3C00);
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("t6_rst_inrdy", 32'(in_ready), 32'd1);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("t6_no_valid", 32'(seen), 32'd0);
    op_const("t6_after",  16'h3C00, 16'hBC00, 16'h4000, 1'b0, 3, 0);

    // Randomized operands against the reference model
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = {ra[15], 15'h0};
        1: rb = {rb[15], 15'h0};
        2: rb = ra;
        3: rb = {rb[15], ra[14:10], rb[9:0]};
        4: rb = {ra[15], ra[14:10], ra[9:2], rb[1:0]};
        default: ;
      endcase
      op_model("rnd", ra, rb, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
